serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: half adder + half adder + OR, with a registered carry between bits.
// Latency: result valid in the cycle after the WIDTH-th edge following the accept edge; no overlap.
// Backpressure: in_ready only in IDLE; sum/cout held in DONE until out_ready is seen at an edge.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter is wide enough to hold WIDTH, so it never wraps before reaching the last bit.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             s1, c1, s2, c2;
  logic [WIDTH-1:0] sum_shift;

  // One-bit full adder cell built from two half adders; carry out is c1|c2.
  always_comb begin
    s1 = a_sh_q[0] ^ b_sh_q[0];
    c1 = a_sh_q[0] & b_sh_q[0];
    s2 = s1 ^ carry_q;
    c2 = s1 & carry_q;
  end

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at sum[0].
  if (WIDTH == 1) begin : g_w1
    assign sum_shift = s2;
  end else begin : g_wn
    assign sum_shift = {s2, sum_sh_q[WIDTH-1:1]};
  end

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        carry_d  = c1 | c2;
        sum_sh_d = sum_shift;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Visible result only moves here, so it is stable for the whole DONE phase.
          cout_d  = c1 | c2;
          sum_d   = sum_shift;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=1 instance
  logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1;
  logic [0:0] a1, b1, sum1;

  int vectors = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1ns later; valid and ready must never coexist.
  task automatic tick();
    @(posedge clk);
    #1;
    check("excl8", {63'd0, out_valid8 & in_ready8}, 64'd0);
    check("excl1", {63'd0, out_valid1 & in_ready1}, 64'd0);
  endtask

  // Issue one operation on the 8-bit DUT; returns cycles from accept edge to out_valid.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, output int lat);
    a8 = ta; b8 = tb_v; cin8 = tc; in_valid8 = 1'b1;
    check("ready_before_accept", {63'd0, in_ready8}, 64'd1);
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      check("busy_in_ready", {63'd0, in_ready8}, 64'd0);
      // Garbage on the input side while busy must be ignored.
      in_valid8 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      tick();
      lat++;
    end
    in_valid8 = 1'b0;
  endtask

  logic [8:0] exp9;
  logic [8:0] q[$];
  int         lat;

  initial begin
    rst_n = 1'b0;
    in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; cin8 = 0;
    in_valid1 = 0; out_ready1 = 1; a1 = 0; b1 = 0; cin1 = 0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready", {63'd0, in_ready8}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid8}, 64'd0);
    check("rst_result", {55'd0, cout8, sum8}, 64'd0);
    check("rst1_in_ready", {63'd0, in_ready1}, 64'd1);

    // 0x5A + 0x33: latency, single-cycle valid, ready afterwards
    op8(8'h5A, 8'h33, 1'b0, lat);
    check("lat_5a33", 64'(lat), 64'd8);
    check("res_5a33", {55'd0, cout8, sum8}, 64'h08D);
    tick();
    check("oneshot_valid", {63'd0, out_valid8}, 64'd0);
    check("oneshot_ready", {63'd0, in_ready8}, 64'd1);

    // Overflow and full carry propagation
    op8(8'hFF, 8'h01, 1'b0, lat);
    check("res_ff01", {55'd0, cout8, sum8}, 64'h100);
    tick();
    op8(8'hFF, 8'hFF, 1'b1, lat);
    check("res_ffff1", {55'd0, cout8, sum8}, 64'h1FF);
    tick();

    // Backpressure with in_valid asserted during the stall
    out_ready8 = 1'b0;
    op8(8'h12, 8'h34, 1'b0, lat);
    a8 = 8'hEE; b8 = 8'hEE; cin8 = 1'b1; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {63'd0, out_valid8}, 64'd1);
      check("stall_res", {55'd0, cout8, sum8}, 64'h046);
      check("stall_ready", {63'd0, in_ready8}, 64'd0);
      tick();
    end
    check("stall_end_res", {55'd0, cout8, sum8}, 64'h046);
    out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    check("release_valid", {63'd0, out_valid8}, 64'd0);
    check("release_ready", {63'd0, in_ready8}, 64'd1);

    // Reset after 3 ADD cycles
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", {63'd0, out_valid8}, 64'd0);
    check("midrst_ready", {63'd0, in_ready8}, 64'd1);
    check("midrst_res", {55'd0, cout8, sum8}, 64'd0);
    op8(8'h0F, 8'h01, 1'b0, lat);
    check("lat_after_rst", 64'(lat), 64'd8);
    check("res_0f01", {55'd0, cout8, sum8}, 64'h010);
    tick();

    // WIDTH=1: full-adder truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; in_valid1 = 1'b1;
      check("w1_ready", {63'd0, in_ready1}, 64'd1);
      tick();
      in_valid1 = 1'b0;
      check("w1_busy", {63'd0, out_valid1}, 64'd0);
      tick();
      check("w1_valid", {63'd0, out_valid1}, 64'd1);
      check("w1_res", {62'd0, cout1, sum1}, 64'(int'(v[2]) + int'(v[1]) + int'(v[0])));
      tick();
      check("w1_back_idle", {63'd0, in_ready1}, 64'd1);
    end

    // Random operations with idle gaps and output stalls; queue tracks outstanding results
    for (int k = 0; k < 1000; k++) begin
      logic [7:0] ra, rb;
      logic       rc;
      int         gap, stall;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        in_valid8 = 1'b0;
        tick();
        check("gap_ready", {63'd0, in_ready8}, 64'd1);
      end
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      q.push_back(exp9);
      stall = $urandom_range(0, 3);
      out_ready8 = (stall == 0);
      op8(ra, rb, rc, lat);
      check("rnd_lat", 64'(lat), 64'd8);
      for (int s = 0; s < stall; s++) begin
        tick();
        check("rnd_stall_valid", {63'd0, out_valid8}, 64'd1);
      end
      out_ready8 = 1'b1;
      check("rnd_pending", 64'(q.size()), 64'd1);
      if (q.size() > 0) begin
        exp9 = q.pop_front();
        check("rnd_res", {55'd0, cout8, sum8}, {55'd0, exp9});
      end
      tick();
      check("rnd_no_dup", {63'd0, out_valid8}, 64'd0);
    end
    check("rnd_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
